me_search_column_loader: RTL and testbench

Upstream feeder for the 2-column search-window buffer in the block-matching motion estimator. It accepts a raster-free, column-ordered stream of 8-bit search-area pixels over a valid/ready handshake. It writes each column into one of the buffer's two 47-entry column slots, and tracks which slots hold a complete column the SAD engine may read. It ping-pongs between slots so the next column loads while the engine consumes the current one.

---
 rtl/me_pkg.sv | 17 +
 rtl/me_slot_tracker.sv | 32 +++
 rtl/me_search_column_loader.sv | 190 +++++++++++++++++++
 tb/tb_me_search_column_loader.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/me_pkg.sv
// rtl/me_pkg.sv - shared constants and loader FSM state for the motion-estimation search path
package me_pkg;

  localparam int DEF_COL_HEIGHT = 47;
  localparam int DEF_ADDR_W     = 7;
  localparam int DEF_DATA_W     = 8;
  localparam int NUM_SLOTS      = 2;
  localparam int SLOT_W         = $clog2(NUM_SLOTS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_SLOT,
    ST_LOAD,
    ST_FINISH
  } ld_state_e;

endpackage

// File: rtl/me_slot_tracker.sv
// rtl/me_slot_tracker.sv - per-slot "column complete" flags with set/release and a free-slot query
module me_slot_tracker
  import me_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_SLOTS-1:0] set_slot,
  input  logic [NUM_SLOTS-1:0] rel_slot,
  input  logic [SLOT_W-1:0]    qry_slot,
  output logic                 qry_free,
  output logic [NUM_SLOTS-1:0] col_avail
);

  logic [NUM_SLOTS-1:0] avail_q, avail_d;

  // A slot is only refilled once released, so set and release never hit the same bit together.
  always_comb begin
    avail_d = (avail_q & ~rel_slot) | set_slot;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      avail_q <= '0;
    end else begin
      avail_q <= avail_d;
    end
  end

  assign col_avail = avail_q;
  assign qry_free  = ~avail_q[qry_slot];

endmodule

// File: rtl/me_search_column_loader.sv
// rtl/me_search_column_loader.sv - ping-pong column loader for the 2-slot search-window buffer
// Optional ME_LOADER_STATS_EN adds a saturating stall_cnt output.
module me_search_column_loader
  import me_pkg::*;
#(
  parameter int COL_HEIGHT = DEF_COL_HEIGHT,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        num_cols,
  input  logic              pix_valid,
  input  logic [DATA_W-1:0] pix_data,
  output logic              pix_ready,
  output logic              search_write,
  output logic [ADDR_W-1:0] search_write_addr,
  output logic [DATA_W-1:0] search_write_data,
  output logic [1:0]        col_avail,
  input  logic [1:0]        col_release,
  output logic              busy,
  output logic              done
`ifdef ME_LOADER_STATS_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  localparam int ROW_W = $clog2(COL_HEIGHT);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(COL_HEIGHT - 1);

  ld_state_e             state_q, state_d;
  logic [ROW_W-1:0]      row_q, row_d;
  logic [SLOT_W-1:0]     wr_slot_q, wr_slot_d;
  logic [7:0]            cols_left_q, cols_left_d;
  logic                  pix_ready_q, pix_ready_d;
  logic                  wr_q, wr_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     data_q, data_d;
  logic [NUM_SLOTS-1:0]  commit_q, commit_d;
  logic                  done_q, done_d;

  logic                  accept_start;
  logic                  beat;
  logic                  last_beat;
  logic [SLOT_W-1:0]     qry_slot;
  logic                  qry_free;

  // A start arriving in the done cycle is still "busy" and is dropped.
  assign accept_start = (state_q == ST_IDLE) && start && !done_q;
  assign beat         = pix_ready_q && pix_valid;
  assign last_beat    = beat && (row_q == ROW_LAST);

  // In LOAD the only question is whether the slot after this column is free.
  assign qry_slot = (state_q == ST_LOAD) ? ~wr_slot_q : wr_slot_q;

  me_slot_tracker u_slot_tracker (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_slot  (commit_q),
    .rel_slot  (col_release),
    .qry_slot  (qry_slot),
    .qry_free  (qry_free),
    .col_avail (col_avail)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_start) begin
          state_d = (num_cols == 8'd0) ? ST_FINISH : ST_WAIT_SLOT;
        end
      end
      ST_WAIT_SLOT: begin
        if (qry_free) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (last_beat) begin
          if (cols_left_q == 8'd1) begin
            state_d = ST_FINISH;
          end else if (!qry_free) begin
            state_d = ST_WAIT_SLOT;
          end
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pix_ready_d = (state_d == ST_LOAD);
    done_d      = (state_q == ST_FINISH);
  end

  always_comb begin
    row_d       = row_q;
    wr_slot_d   = wr_slot_q;
    cols_left_d = cols_left_q;
    wr_d        = 1'b0;
    addr_d      = addr_q;
    data_d      = data_q;
    commit_d    = '0;
    if (accept_start) begin
      row_d       = '0;
      wr_slot_d   = '0;
      cols_left_d = num_cols;
    end else if (beat) begin
      wr_d   = 1'b1;
      addr_d = ADDR_W'(row_q) + ((wr_slot_q != '0) ? ADDR_W'(COL_HEIGHT) : ADDR_W'(0));
      data_d = pix_data;
      if (last_beat) begin
        row_d              = '0;
        wr_slot_d          = ~wr_slot_q;
        cols_left_d        = cols_left_q - 8'd1;
        commit_d[wr_slot_q] = 1'b1;
      end else begin
        row_d = row_q + ROW_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q       <= '0;
      wr_slot_q   <= '0;
      cols_left_q <= '0;
      pix_ready_q <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      commit_q    <= '0;
      done_q      <= 1'b0;
    end else begin
      row_q       <= row_d;
      wr_slot_q   <= wr_slot_d;
      cols_left_q <= cols_left_d;
      pix_ready_q <= pix_ready_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      commit_q    <= commit_d;
      done_q      <= done_d;
    end
  end

  assign pix_ready         = pix_ready_q;
  assign search_write      = wr_q;
  assign search_write_addr = addr_q;
  assign search_write_data = data_q;
  assign done              = done_q;
  assign busy              = (state_q != ST_IDLE) || done_q;

`ifdef ME_LOADER_STATS_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (accept_start) begin
      stall_d = '0;
    end else if (((state_q == ST_WAIT_SLOT) || ((state_q == ST_LOAD) && !pix_valid))
                 && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_me_search_column_loader.sv
// tb/tb_me_search_column_loader.sv - directed bench for the search column loader
module tb_me_search_column_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] num_cols;
  logic       pix_valid;
  logic [7:0] pix_data;
  logic       pix_ready;
  logic       search_write;
  logic [6:0] search_write_addr;
  logic [7:0] search_write_data;
  logic [1:0] col_avail;
  logic [1:0] col_release;
  logic       busy;
  logic       done;
`ifdef ME_LOADER_STATS_EN
  logic [15:0] stall_cnt;
`endif

  int total = 0;
  int bad   = 0;
  int wcount = 0;
  int exp_addr_q[$];
  int exp_data_q[$];

  typedef struct {
    logic [1:0] rel;
    logic [1:0] exp_avail;
  } rel_vec_t;

  always #5 clk = ~clk;

  me_search_column_loader dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start),
    .num_cols          (num_cols),
    .pix_valid         (pix_valid),
    .pix_data          (pix_data),
    .pix_ready         (pix_ready),
    .search_write      (search_write),
    .search_write_addr (search_write_addr),
    .search_write_data (search_write_data),
    .col_avail         (col_avail),
    .col_release       (col_release),
    .busy              (busy),
    .done              (done)
`ifdef ME_LOADER_STATS_EN
    ,
    .stall_cnt         (stall_cnt)
`endif
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Scoreboard: every buffer write must match the next beat the driver handed over.
  always @(negedge clk) begin
    if (rst_n && search_write) begin
      wcount++;
      if (exp_addr_q.size() == 0) begin
        chk("write_expected", exp_addr_q.size(), 1);
      end else begin
        chk("write_addr", int'(search_write_addr), exp_addr_q.pop_front());
        chk("write_data", int'(search_write_data), exp_data_q.pop_front());
      end
    end
  end

  task automatic feed(input int nbeats, input int base_addr, input int seed, input bit gap);
    int sent = 0;
    int cyc  = 0;
    while (sent < nbeats && cyc < 2000) begin
      @(negedge clk);
      pix_valid = gap ? ((cyc % 2) == 0) : 1'b1;
      pix_data  = 8'(seed + sent);
      if (pix_valid && pix_ready) begin
        exp_addr_q.push_back(base_addr + sent);
        exp_data_q.push_back((seed + sent) & 255);
        sent++;
      end
      cyc++;
    end
    @(negedge clk);
    pix_valid = 1'b0;
    if (sent < nbeats) chk("feed_timeout", sent, nbeats);
  endtask

  task automatic do_start(input int n);
    @(negedge clk);
    start    = 1'b1;
    num_cols = 8'(n);
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic pulse_release(input logic [1:0] r);
    @(negedge clk);
    col_release = r;
    @(negedge clk);
    col_release = 2'b00;
  endtask

  task automatic wait_done(input string name);
    int cyc = 0;
    while (done !== 1'b1 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    chk(name, int'(done), 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_pix_ready"}, int'(pix_ready), 0);
    chk({tag, "_write"}, int'(search_write), 0);
    chk({tag, "_addr"}, int'(search_write_addr), 0);
    chk({tag, "_data"}, int'(search_write_data), 0);
    chk({tag, "_col_avail"}, int'(col_avail), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
  endtask

  initial begin
    rel_vec_t rel_tab[5];
    int w0;

    rel_tab[0] = '{rel: 2'b00, exp_avail: 2'b11};
    rel_tab[1] = '{rel: 2'b10, exp_avail: 2'b01};
    rel_tab[2] = '{rel: 2'b10, exp_avail: 2'b01};
    rel_tab[3] = '{rel: 2'b01, exp_avail: 2'b00};
    rel_tab[4] = '{rel: 2'b11, exp_avail: 2'b00};

    rst_n       = 1'b0;
    start       = 1'b0;
    num_cols    = 8'd0;
    pix_valid   = 1'b0;
    pix_data    = 8'd0;
    col_release = 2'b00;
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst");
    rst_n = 1'b1;

    // One column, continuous beats.
    do_start(1);
    chk("a_busy_after_start", int'(busy), 1);
    feed(47, 0, 8'h10, 1'b0);
    chk("a_avail_last_write", int'(col_avail), 0);
    chk("a_done_early", int'(done), 0);
    @(negedge clk);
    chk("a_avail_set", int'(col_avail), 1);
    chk("a_done", int'(done), 1);
    chk("a_busy_done", int'(busy), 1);
    @(negedge clk);
    chk("a_done_clear", int'(done), 0);
    chk("a_busy_clear", int'(busy), 0);
    chk("a_writes", wcount, 47);

    pulse_release(2'b01);
    chk("free_slot0", int'(col_avail), 0);

    // Three columns, no release until the FSM parks in WAIT_SLOT.
    w0 = wcount;
    do_start(3);
    feed(94, 0, 8'h40, 1'b0);
    @(negedge clk);
    chk("b_avail_full", int'(col_avail), 3);
    chk("b_wait_ready", int'(pix_ready), 0);
    chk("b_wait_busy", int'(busy), 1);
    do_start(9);
    pulse_release(2'b01);
    chk("b_bubble_ready", int'(pix_ready), 0);
    chk("b_avail_rel", int'(col_avail), 2);
    @(negedge clk);
    chk("b_ready_rise", int'(pix_ready), 1);
    feed(47, 0, 8'h80, 1'b0);
    wait_done("b_done");
    chk("b_avail_end", int'(col_avail), 3);
    chk("b_writes", wcount - w0, 141);
    @(negedge clk);
    chk("b_idle", int'(busy), 0);

    for (int i = 0; i < 5; i++) begin
      pulse_release(rel_tab[i].rel);
      chk($sformatf("rel_tab%0d", i), int'(col_avail), int'(rel_tab[i].exp_avail));
    end

    // Two columns with pix_valid toggling.
    w0 = wcount;
    do_start(2);
    feed(94, 0, 8'hC0, 1'b1);
    wait_done("c_done");
    chk("c_busy_done", int'(busy), 1);
    @(negedge clk);
    chk("c_busy_drop", int'(busy), 0);
    chk("c_writes", wcount - w0, 94);
    pulse_release(2'b11);

    // Reset in the middle of a column.
    do_start(1);
    feed(20, 0, 8'h20, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("mid_rst");
    exp_addr_q.delete();
    exp_data_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    w0 = wcount;
    do_start(1);
    feed(47, 0, 8'h55, 1'b0);
    wait_done("d_done");
    chk("d_avail", int'(col_avail), 1);
    chk("d_writes", wcount - w0, 47);

    // num_cols = 0: done two cycles after start, no writes, slots untouched.
    w0 = wcount;
    @(negedge clk);
    do_start(0);
    chk("e_done_early", int'(done), 0);
    chk("e_busy", int'(busy), 1);
    @(negedge clk);
    chk("e_done", int'(done), 1);
    @(negedge clk);
    chk("e_done_clear", int'(done), 0);
    chk("e_busy_clear", int'(busy), 0);
    chk("e_no_writes", wcount - w0, 0);
    chk("e_avail_kept", int'(col_avail), 1);

`ifdef ME_LOADER_STATS_EN
    // 1 initial WAIT cycle + 5 valid-low LOAD cycles + 9 WAIT cycles before slot 0 frees.
    pulse_release(2'b01);
    do_start(3);
    repeat (5) @(negedge clk);
    feed(94, 0, 8'h01, 1'b0);
    repeat (6) @(negedge clk);
    pulse_release(2'b01);
    feed(47, 0, 8'h02, 1'b0);
    wait_done("s_done");
    chk("s_stall_cnt", int'(stall_cnt), 15);
`endif

    chk("leftover_expected", exp_addr_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
